// File: rtl/alu_operand_stage.sv
// ID/EX operand stage: resolves ALU operands from the register file, the
// EX/MEM and MEM/WB forwarding paths, the immediate or the PC, and keeps them
// in a single registered entry. A held entry watches the writeback paths so
// its operands pick up results that arrive while it waits.
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  input  logic [31:0] in_imm,
  input  logic [31:0] in_pc,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [3:0]  in_FuncCode,
  input  logic [6:0]  in_Opcode,
  input  logic        in_alusrc_pc,
  input  logic        in_alusrc_imm,
  input  logic        flush,
  input  logic        exmem_wr_en,
  input  logic        memwb_wr_en,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_data,
  input  logic [31:0] memwb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [3:0]  FuncCode,
  output logic [6:0]  Opcode,
  output logic [4:0]  out_rd,
  output logic [15:0] stall_count
);

  // Result of looking a register index up on the two forwarding paths.
  typedef struct packed {
    logic        hit;
    logic [31:0] data;
  } fwd_t;

  // EX/MEM wins over MEM/WB; x0 never matches so it is never forwarded.
  function automatic fwd_t fwd_lookup(
    input logic [4:0]  r,
    input logic        ex_en,
    input logic [4:0]  ex_rd,
    input logic [31:0] ex_data,
    input logic        mw_en,
    input logic [4:0]  mw_rd,
    input logic [31:0] mw_data
  );
    fwd_t res;
    res = '0;
    if (r != 5'd0) begin
      if (ex_en && ex_rd == r) begin
        res.hit  = 1'b1;
        res.data = ex_data;
      end else if (mw_en && mw_rd == r) begin
        res.hit  = 1'b1;
        res.data = mw_data;
      end
    end
    return res;
  endfunction

  logic        valid_q;
  logic [31:0] a_q, b_q;
  logic [3:0]  func_q;
  logic [6:0]  op_q;
  logic [4:0]  rd_q, rs1_q, rs2_q;
  logic        use_rs1_q, use_rs2_q;
  logic [15:0] stall_q;

  logic        capture, hold;
  logic [31:0] a_d, b_d;
  fwd_t        in1_fwd, in2_fwd, snp1_fwd, snp2_fwd;
  logic        snp_a, snp_b;

  // Handshake, capture-time operand select and held-entry snoop decisions.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    a_d      = '0;
    b_d      = '0;
    in_ready = !flush && (!valid_q || out_ready);
    capture  = in_valid && in_ready;
    hold     = valid_q && !out_ready && !flush;

    in1_fwd  = fwd_lookup(in_rs1, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
    in2_fwd  = fwd_lookup(in_rs2, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
    snp1_fwd = fwd_lookup(rs1_q, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);
    snp2_fwd = fwd_lookup(rs2_q, exmem_wr_en, exmem_rd, exmem_data,
                          memwb_wr_en, memwb_rd, memwb_data);

    if (in_alusrc_pc)        a_d = in_pc;
    else if (in_rs1 == 5'd0) a_d = '0;
    else if (in1_fwd.hit)    a_d = in1_fwd.data;
    else                     a_d = in_rs1_data;

    if (in_alusrc_imm)       b_d = in_imm;
    else if (in_rs2 == 5'd0) b_d = '0;
    else if (in2_fwd.hit)    b_d = in2_fwd.data;
    else                     b_d = in_rs2_data;

    snp_a = use_rs1_q && snp1_fwd.hit;
    snp_b = use_rs2_q && snp2_fwd.hit;
  end

  // Pipeline entry: flush beats capture, capture beats hold/snoop, else drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      func_q    <= '0;
      op_q      <= '0;
      rd_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      use_rs1_q <= 1'b0;
      use_rs2_q <= 1'b0;
      stall_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      if (valid_q && !out_ready && stall_q != 16'hFFFF)
        stall_q <= stall_q + 16'd1;

      if (flush) begin
        valid_q <= 1'b0;
      end else if (capture) begin
        valid_q   <= 1'b1;
        a_q       <= a_d;
        b_q       <= b_d;
        func_q    <= in_FuncCode;
        op_q      <= in_Opcode;
        rd_q      <= in_rd;
        rs1_q     <= in_rs1;
        rs2_q     <= in_rs2;
        use_rs1_q <= !in_alusrc_pc;
        use_rs2_q <= !in_alusrc_imm;
      end else if (hold) begin
        if (snp_a) a_q <= snp1_fwd.data;
        if (snp_b) b_q <= snp2_fwd.data;
      end else if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid   = valid_q;
  assign A           = a_q;
  assign B           = b_q;
  assign FuncCode    = func_q;
  assign Opcode      = op_q;
  assign out_rd      = rd_q;
  assign stall_count = stall_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: forwarding priority, hold/snoop,
// operand source select, flush, async reset and stall counter saturation.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [3:0]  in_FuncCode;
  logic [6:0]  in_Opcode;
  logic        in_alusrc_pc, in_alusrc_imm, flush;
  logic        exmem_wr_en, memwb_wr_en;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_data, memwb_data;
  logic        out_valid, out_ready;
  logic [31:0] A, B;
  logic [3:0]  FuncCode;
  logic [6:0]  Opcode;
  logic [4:0]  out_rd;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_pc(in_pc), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_FuncCode(in_FuncCode), .in_Opcode(in_Opcode),
    .in_alusrc_pc(in_alusrc_pc), .in_alusrc_imm(in_alusrc_imm), .flush(flush),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data),
    .out_valid(out_valid), .out_ready(out_ready), .A(A), .B(B),
    .FuncCode(FuncCode), .Opcode(Opcode), .out_rd(out_rd),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge before sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush = 1'b0;
    in_rs1_data = '0; in_rs2_data = '0; in_imm = '0; in_pc = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_FuncCode = '0; in_Opcode = '0;
    in_alusrc_pc = 1'b0; in_alusrc_imm = 1'b0;
    exmem_wr_en = 1'b0; memwb_wr_en = 1'b0; exmem_rd = '0; memwb_rd = '0;
    exmem_data = '0; memwb_data = '0;
    #12;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_A", A, 32'd0);
    check("rst_B", B, 32'd0);
    check("rst_func_op", {21'd0, FuncCode, Opcode}, 32'd0);
    check("rst_stall", {16'd0, stall_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD with no hazards
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs2 = 5'd2; in_rd = 5'd3;
    in_rs1_data = 32'd10000; in_rs2_data = 32'd111;
    in_FuncCode = 4'b0000; in_Opcode = 7'b0110011;
    step();
    in_valid = 1'b0;
    check("add_valid", {31'd0, out_valid}, 32'd1);
    check("add_A", A, 32'd10000);
    check("add_B", B, 32'd111);
    check("add_opcode", {25'd0, Opcode}, 32'h33);
    check("add_rd", {27'd0, out_rd}, 32'd3);
    check("add_sum", A + B, 32'd10111);
    step();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_A_kept", A, 32'd10000);

    // Forward priority, back-to-back captures
    in_valid = 1'b1; in_rs1 = 5'd5; in_rs1_data = 32'h1111;
    in_rs2 = 5'd6; in_rs2_data = 32'h22;
    exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_data = 32'hAAAA;
    memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'hBBBB;
    step();
    check("fwd_both_A", A, 32'hAAAA);
    check("fwd_none_B", B, 32'h22);
    exmem_wr_en = 1'b0;
    step();
    check("fwd_memwb_A", A, 32'hBBBB);
    check("b2b_valid", {31'd0, out_valid}, 32'd1);
    in_rs1 = 5'd0; in_rs1_data = 32'h1234;
    exmem_wr_en = 1'b1; exmem_rd = 5'd0; exmem_data = 32'hCCCC;
    memwb_rd = 5'd6; memwb_data = 32'h6666;
    step();
    check("fwd_x0_A", A, 32'd0);
    check("fwd_memwb_B", B, 32'h6666);
    exmem_wr_en = 1'b0; memwb_wr_en = 1'b0; in_valid = 1'b0;
    step();
    check("fwd_drain", {31'd0, out_valid}, 32'd0);

    // Stall + snoop on rs2
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs1_data = 32'd1;
    in_rs2 = 5'd7; in_rs2_data = 32'h77; out_ready = 1'b0;
    step();
    check("stl_cap_B", B, 32'h77);
    check("stl_cap_cnt", {16'd0, stall_count}, 32'd0);
    in_rs2_data = 32'h99;  // a competing instruction that must not enter
    #1 check("stl_rdy1", {31'd0, in_ready}, 32'd0);
    step();
    check("stl_B1", B, 32'h77);
    memwb_wr_en = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h55;
    #1 check("stl_rdy2", {31'd0, in_ready}, 32'd0);
    step();
    check("stl_snoop_B", B, 32'h55);
    memwb_wr_en = 1'b0;
    #1 check("stl_rdy3", {31'd0, in_ready}, 32'd0);
    step();
    check("stl_held_B", B, 32'h55);
    check("stl_cnt3", {16'd0, stall_count}, 32'd3);
    check("stl_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    check("stl_release", {31'd0, out_valid}, 32'd0);
    check("stl_cnt_kept", {16'd0, stall_count}, 32'd3);

    // Immediate / PC select, snoop must not touch them
    in_valid = 1'b1; in_alusrc_imm = 1'b1; in_imm = 32'hFFFF_FFFF; in_rs2 = 5'd7;
    in_alusrc_pc = 1'b1; in_pc = 32'h100; in_rs1 = 5'd3; out_ready = 1'b0;
    step();
    check("sel_A_pc", A, 32'h100);
    check("sel_B_imm", B, 32'hFFFF_FFFF);
    in_valid = 1'b0; in_alusrc_imm = 1'b0; in_alusrc_pc = 1'b0;
    memwb_wr_en = 1'b1; memwb_rd = 5'd7; memwb_data = 32'h55;
    exmem_wr_en = 1'b1; exmem_rd = 5'd3; exmem_data = 32'h33;
    step();
    check("sel_B_nosnoop", B, 32'hFFFF_FFFF);
    check("sel_A_nosnoop", A, 32'h100);
    check("sel_cnt", {16'd0, stall_count}, 32'd4);
    memwb_wr_en = 1'b0; exmem_wr_en = 1'b0;

    // Flush beats capture
    flush = 1'b1; in_valid = 1'b1; in_rs1 = 5'd4; in_rs1_data = 32'hF00D;
    in_rs2 = 5'd8; in_rs2_data = 32'hBEEF;
    #1 check("fl_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("fl_valid", {31'd0, out_valid}, 32'd0);
    check("fl_A_kept", A, 32'h100);
    check("fl_B_kept", B, 32'hFFFF_FFFF);
    check("fl_cnt", {16'd0, stall_count}, 32'd5);
    flush = 1'b0; in_valid = 1'b0;

    // Reset mid-hold clears immediately
    in_valid = 1'b1; in_rs1 = 5'd9; in_rs1_data = 32'hDEAD;
    step();
    in_valid = 1'b0;
    step();
    check("rh_pre_A", A, 32'hDEAD);
    rst_n = 1'b0;
    #1;
    check("rh_valid", {31'd0, out_valid}, 32'd0);
    check("rh_A", A, 32'd0);
    check("rh_B", B, 32'd0);
    check("rh_cnt", {16'd0, stall_count}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    step();
    check("rh_cnt_after", {16'd0, stall_count}, 32'd0);

    // Stall counter saturation
    in_valid = 1'b1; in_rs1 = 5'd1; in_rs1_data = 32'd1;
    step();
    in_valid = 1'b0;
    repeat (65540) step();
    check("sat_cnt", {16'd0, stall_count}, 32'h0000_FFFF);
    check("sat_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    step();
    check("sat_cnt_kept", {16'd0, stall_count}, 32'h0000_FFFF);
    check("sat_drain", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
